motion_ctrl_axil_slave: RTL and testbench

AXI4-Lite slave that terminates the master-side register traffic driven by the motion-controller test and driver software. It holds the motion-controller register file: control, two PWM duty values, the PWM period and a read-only status word. It drives a left/right PWM generator that feeds the motor drivers of the car. It sits behind the S00_AXI interconnect port.

---
 rtl/motion_ctrl_pkg.sv | 37 +++
 rtl/motion_pwm_gen.sv | 68 ++++++
 rtl/motion_ctrl_axil_slave.sv | 187 ++++++++++++++++++
 tb/tb_motion_ctrl_axil_slave.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motion_ctrl_pkg.sv
// Motion-controller register map, AXI response codes, CTRL bit positions,
// the register-file record and the byte-strobe merge helper shared by the
// AXI4-Lite slave.
package motion_ctrl_pkg;

  localparam logic [4:0] ADDR_CTRL   = 5'h00;
  localparam logic [4:0] ADDR_DUTY_L = 5'h04;
  localparam logic [4:0] ADDR_DUTY_R = 5'h08;
  localparam logic [4:0] ADDR_PERIOD = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_DIR_L_BIT = 1;
  localparam int unsigned CTRL_DIR_R_BIT = 2;

  typedef struct packed {
    logic [31:0] ctrl;
    logic [31:0] duty_l;
    logic [31:0] duty_r;
    logic [31:0] period;
  } regfile_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/motion_pwm_gen.sv
// Left/right PWM generator.
//   clk, rst            : clock, asynchronous active-high reset
//   enable              : gates both PWM outputs (counter keeps running)
//   period, duty_l/_r   : live register values, sampled into shadows at wrap
//   cnt                 : current counter value
//   pwm_left/pwm_right  : compare outputs
//   period_tick         : one-cycle pulse in the cycle the counter is back at 0
module motion_pwm_gen #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty_l,
  input  logic [CNT_W-1:0] duty_r,
  output logic [CNT_W-1:0] cnt,
  output logic             pwm_left,
  output logic             pwm_right,
  output logic             period_tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] sh_period_q, sh_period_d;
  logic [CNT_W-1:0] sh_duty_l_q, sh_duty_l_d;
  logic [CNT_W-1:0] sh_duty_r_q, sh_duty_r_d;
  logic             tick_q, tick_d;
  logic             wrap;

  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    sh_period_d = sh_period_q;
    sh_duty_l_d = sh_duty_l_q;
    sh_duty_r_d = sh_duty_r_q;
    wrap        = (sh_period_q != '0) && (cnt_q == sh_period_q - CNT_W'(1));
    tick_d      = wrap;
    // A zero shadow period keeps reloading so a fresh PERIOD is picked up
    // immediately instead of waiting for a wrap that would never come.
    if (wrap || sh_period_q == '0) begin
      cnt_d       = '0;
      sh_period_d = period;
      sh_duty_l_d = duty_l;
      sh_duty_r_d = duty_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      sh_period_q <= '0;
      sh_duty_l_q <= '0;
      sh_duty_r_q <= '0;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sh_period_q <= sh_period_d;
      sh_duty_l_q <= sh_duty_l_d;
      sh_duty_r_q <= sh_duty_r_d;
      tick_q      <= tick_d;
    end
  end

  assign cnt         = cnt_q;
  assign period_tick = tick_q;
  assign pwm_left    = enable && (sh_period_q != '0) && (cnt_q < sh_duty_l_q);
  assign pwm_right   = enable && (sh_period_q != '0) && (cnt_q < sh_duty_r_q);

endmodule

// File: rtl/motion_ctrl_axil_slave.sv
// AXI4-Lite slave holding the motion-controller register file
// (CTRL, DUTY_L, DUTY_R, PERIOD, read-only STATUS) and driving the PWM.
//   ACLK/ARESET      : clock, asynchronous active-high reset
//   S_AXI_*          : AXI4-Lite slave port (AWPROT/ARPROT ignored)
//   pwm_left/right   : motor PWM outputs
//   dir_left/right   : CTRL[1] / CTRL[2]
//   period_tick      : pulse when the PWM counter wraps to 0
module motion_ctrl_axil_slave
  import motion_ctrl_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int PWM_CNT_WIDTH      = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            pwm_left,
  output logic                            pwm_right,
  output logic                            dir_left,
  output logic                            dir_right,
  output logic                            period_tick
);

  logic        ready_en_q, ready_en_d;
  logic        aw_held_q, aw_held_d;
  logic [4:0]  aw_addr_q, aw_addr_d;
  logic        w_held_q, w_held_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  regfile_t    regs_q, regs_d;

  logic [PWM_CNT_WIDTH-1:0] pwm_cnt;
  logic [31:0]              status_word;
  logic                     aw_hs, w_hs, ar_hs;
  logic                     unused_ok;

  // ready_en_q keeps every ready low while ARESET is asserted.
  assign S_AXI_AWREADY = ready_en_q && !aw_held_q && !bvalid_q;
  assign S_AXI_WREADY  = ready_en_q && !w_held_q && !bvalid_q;
  assign S_AXI_ARREADY = ready_en_q && !rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign dir_left      = regs_q.ctrl[CTRL_DIR_L_BIT];
  assign dir_right     = regs_q.ctrl[CTRL_DIR_R_BIT];

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    status_word                   = '0;
    status_word[PWM_CNT_WIDTH-1:0] = pwm_cnt;
    status_word[16]               = regs_q.ctrl[CTRL_EN_BIT];
  end

  always_comb begin
    ready_en_d = 1'b1;
    aw_held_d  = aw_held_q;
    aw_addr_d  = aw_addr_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    regs_d     = regs_q;

    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = {S_AXI_AWADDR[4:2], 2'b00};
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end

    if (aw_held_q && w_held_q) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_OKAY;
      case (aw_addr_q)
        ADDR_CTRL:   regs_d.ctrl   = apply_wstrb(regs_q.ctrl,   wdata_q, wstrb_q);
        ADDR_DUTY_L: regs_d.duty_l = apply_wstrb(regs_q.duty_l, wdata_q, wstrb_q);
        ADDR_DUTY_R: regs_d.duty_r = apply_wstrb(regs_q.duty_r, wdata_q, wstrb_q);
        ADDR_PERIOD: regs_d.period = apply_wstrb(regs_q.period, wdata_q, wstrb_q);
        ADDR_STATUS: ;
        default:     bresp_d = RESP_SLVERR;
      endcase
    end

    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    // Read mux uses regs_q, so a same-cycle write is not yet visible.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      case ({S_AXI_ARADDR[4:2], 2'b00})
        ADDR_CTRL:   rdata_d = regs_q.ctrl;
        ADDR_DUTY_L: rdata_d = regs_q.duty_l;
        ADDR_DUTY_R: rdata_d = regs_q.duty_r;
        ADDR_PERIOD: rdata_d = regs_q.period;
        ADDR_STATUS: rdata_d = status_word;
        default: begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
        end
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      regs_q     <= '0;
    end else begin
      ready_en_q <= ready_en_d;
      aw_held_q  <= aw_held_d;
      aw_addr_q  <= aw_addr_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      regs_q     <= regs_d;
    end
  end

  motion_pwm_gen #(.CNT_W(PWM_CNT_WIDTH)) u_pwm (
    .clk         (ACLK),
    .rst         (ARESET),
    .enable      (regs_q.ctrl[CTRL_EN_BIT]),
    .period      (regs_q.period[PWM_CNT_WIDTH-1:0]),
    .duty_l      (regs_q.duty_l[PWM_CNT_WIDTH-1:0]),
    .duty_r      (regs_q.duty_r[PWM_CNT_WIDTH-1:0]),
    .cnt         (pwm_cnt),
    .pwm_left    (pwm_left),
    .pwm_right   (pwm_right),
    .period_tick (period_tick)
  );

endmodule

// File: tb/tb_motion_ctrl_axil_slave.sv
module tb_motion_ctrl_axil_slave;

  localparam int TO = 60;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [4:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [4:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic        pwm_left, pwm_right, dir_left, dir_right, period_tick;

  motion_ctrl_axil_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (5),
    .PWM_CNT_WIDTH      (16)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .pwm_left(pwm_left), .pwm_right(pwm_right),
    .dir_left(dir_left), .dir_right(dir_right), .period_tick(period_tick)
  );

  always #5 ACLK = ~ACLK;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  // Reference model: four storage words, responses queued in issue order.
  logic [31:0] ref_regs [4];
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: got timeout, required handshake within %0d cycles", name, TO);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) ref_regs[i] = '0;
  endfunction

  function automatic void model_write(input logic [4:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    int unsigned idx;
    logic [31:0] mask;
    idx  = addr / 4;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    if (idx < 4) begin
      ref_regs[idx] = (ref_regs[idx] & ~mask) | (data & mask);
      exp_b.push_back(2'b00);
    end else if (idx == 4) begin
      exp_b.push_back(2'b00);
    end else begin
      exp_b.push_back(2'b10);
    end
  endfunction

  // STATUS is only predicted while PERIOD is 0, so the counter reads 0.
  function automatic void model_read(input logic [4:0] addr);
    int unsigned idx;
    idx = addr / 4;
    if (idx < 4)       exp_r.push_back({ref_regs[idx], 2'b00});
    else if (idx == 4) exp_r.push_back({32'(ref_regs[0][0]) << 16, 2'b00});
    else               exp_r.push_back({32'h0, 2'b10});
  endfunction

  // Monitor: pops a prediction at every completed B or R handshake.
  always @(negedge ACLK) begin
    if (S_AXI_BVALID && S_AXI_BREADY) begin
      if (exp_b.size() == 0) begin
        n_cmp++; n_mis++;
        $display("FAIL b_unexpected: got BRESP 0x%0h, required no response", S_AXI_BRESP);
      end else begin
        check("bresp", 32'(S_AXI_BRESP), 32'(exp_b.pop_front()));
      end
    end
    if (S_AXI_RVALID && S_AXI_RREADY) begin
      if (exp_r.size() == 0) begin
        n_cmp++; n_mis++;
        $display("FAIL r_unexpected: got RDATA 0x%08h, required no response", S_AXI_RDATA);
      end else begin
        logic [33:0] e;
        e = exp_r.pop_front();
        check("rdata", S_AXI_RDATA, e[33:2]);
        check("rresp", 32'(S_AXI_RRESP), 32'(e[1:0]));
      end
    end
  end

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
  // bdelay < 0 leaves the response pending and predicts nothing.
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, input int bdelay);
    int t;
    logic ok;
    if (bdelay >= 0) model_write(addr, data, strb);
    fork
      begin : w_side
        int tw; logic okw;
        if (lead < 0) repeat (-lead) begin @(posedge ACLK); #1; end
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        tw = 0;
        do begin @(negedge ACLK); okw = S_AXI_WREADY; @(posedge ACLK); #1; tw++; end
        while (!okw && tw < TO);
        S_AXI_WVALID = 1'b0;
        if (!okw) timeout_fail("w_handshake");
      end
      begin : aw_side
        int ta; logic oka;
        if (lead > 0) repeat (lead) begin @(posedge ACLK); #1; end
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
        ta = 0;
        do begin @(negedge ACLK); oka = S_AXI_AWREADY; @(posedge ACLK); #1; ta++; end
        while (!oka && ta < TO);
        S_AXI_AWVALID = 1'b0;
        if (!oka) timeout_fail("aw_handshake");
      end
    join
    if (bdelay >= 0) begin
      repeat (bdelay) begin @(posedge ACLK); #1; end
      S_AXI_BREADY = 1'b1;
      t = 0;
      do begin @(negedge ACLK); ok = S_AXI_BVALID; @(posedge ACLK); #1; t++; end
      while (!ok && t < TO);
      S_AXI_BREADY = 1'b0;
      if (!ok) timeout_fail("b_handshake");
    end
  endtask

  task automatic axi_read(input logic [4:0] addr, input int rdelay);
    int t;
    logic ok;
    model_read(addr);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    t = 0;
    do begin @(negedge ACLK); ok = S_AXI_ARREADY; @(posedge ACLK); #1; t++; end
    while (!ok && t < TO);
    S_AXI_ARVALID = 1'b0;
    if (!ok) timeout_fail("ar_handshake");
    repeat (rdelay) begin @(posedge ACLK); #1; end
    S_AXI_RREADY = 1'b1;
    t = 0;
    do begin @(negedge ACLK); ok = S_AXI_RVALID; @(posedge ACLK); #1; t++; end
    while (!ok && t < TO);
    S_AXI_RREADY = 1'b0;
    if (!ok) timeout_fail("r_handshake");
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge ACLK); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int cl, cr, ct, found;
    model_reset();

    // Reset state
    repeat (3) @(negedge ACLK);
    check("rst_awready", 32'(S_AXI_AWREADY), 0);
    check("rst_wready",  32'(S_AXI_WREADY), 0);
    check("rst_arready", 32'(S_AXI_ARREADY), 0);
    check("rst_bvalid",  32'(S_AXI_BVALID), 0);
    check("rst_rvalid",  32'(S_AXI_RVALID), 0);
    check("rst_rdata",   S_AXI_RDATA, 0);
    check("rst_outs", {27'b0, pwm_left, pwm_right, dir_left, dir_right, period_tick}, 0);
    @(posedge ACLK); #1 ARESET = 1'b0;
    cycles(1);

    // Basic write/readback
    axi_write(5'h00, 32'h1, 4'hF, 0, 0);
    axi_write(5'h04, 32'h2, 4'hF, 0, 0);
    axi_write(5'h08, 32'h3, 4'hF, 0, 0);
    axi_write(5'h0C, 32'h4, 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(5'(i * 4), 0);

    // Byte strobes
    axi_write(5'h04, 32'h0000_0002, 4'hF, 0, 0);
    axi_write(5'h04, 32'hAABB_CCDD, 4'b0010, 0, 0);
    axi_read(5'h04, 0);

    // W three cycles ahead of AW, BREADY held low for five cycles
    model_write(5'h08, 32'h55, 4'hF);
    S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(negedge ACLK); check("t3_wready_idle", 32'(S_AXI_WREADY), 1);
    @(posedge ACLK); #1 S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge ACLK); check("t3_wready_held", 32'(S_AXI_WREADY), 0);
      check("t3_bvalid_early", 32'(S_AXI_BVALID), 0);
      @(posedge ACLK); #1;
    end
    S_AXI_AWADDR = 5'h08; S_AXI_AWVALID = 1'b1;
    @(negedge ACLK); check("t3_awready", 32'(S_AXI_AWREADY), 1);
    @(posedge ACLK); #1 S_AXI_AWVALID = 1'b0;
    @(negedge ACLK); check("t3_bvalid_hs_cycle", 32'(S_AXI_BVALID), 0);
    @(posedge ACLK); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check("t3_bvalid_hold", 32'(S_AXI_BVALID), 1);
      check("t3_bresp_hold", 32'(S_AXI_BRESP), 0);
      check("t3_awready_blk", 32'(S_AXI_AWREADY), 0);
      check("t3_wready_blk", 32'(S_AXI_WREADY), 0);
      @(posedge ACLK); #1;
    end
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    @(posedge ACLK); #1 S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    check("t3_bvalid_clr", 32'(S_AXI_BVALID), 0);
    check("t3_awready_back", 32'(S_AXI_AWREADY), 1);
    @(posedge ACLK); #1;
    axi_read(5'h08, 0);

    // Unmapped and read-only accesses
    axi_write(5'h0C, 32'h0, 4'hF, 0, 0);
    cycles(20);
    axi_write(5'h18, 32'hDEAD_BEEF, 4'hF, 1, 1);
    axi_read(5'h1C, 0);
    axi_read(5'h10, 0);
    axi_write(5'h10, 32'h0000_FFFF, 4'hF, -1, 0);
    axi_read(5'h10, 1);
    for (int i = 0; i < 4; i++) axi_read(5'(i * 4), 0);

    // Randomized traffic (STATUS reads excluded, PERIOD kept small)
    for (int i = 0; i < 40; i++) begin
      logic [4:0] a;
      logic [31:0] d;
      int unsigned sel;
      sel = $urandom_range(0, 7);
      a = 5'(sel * 4) | 5'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        if (sel == 3) d = d & 32'h1F;
        axi_write(a, d, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3,
                  int'($urandom_range(0, 3)));
      end else begin
        if (sel == 4) a = 5'h0C;
        axi_read(a, int'($urandom_range(0, 3)));
      end
    end

    // PWM: period 10, left duty 3, right duty 12 (constant high)
    axi_write(5'h0C, 32'd10, 4'hF, 0, 0);
    axi_write(5'h04, 32'd3, 4'hF, 0, 0);
    axi_write(5'h08, 32'd12, 4'hF, 0, 0);
    axi_write(5'h00, 32'h1, 4'hF, 0, 0);
    cycles(40);
    found = 0;
    for (int t = 0; t < 100 && found == 0; t++) begin
      @(negedge ACLK);
      if (period_tick) found = 1;
    end
    if (found == 0) timeout_fail("pwm_tick_sync");
    else begin
      cl = 0; cr = 0; ct = 0;
      for (int i = 0; i < 30; i++) begin
        cl += int'(pwm_left); cr += int'(pwm_right); ct += int'(period_tick);
        @(negedge ACLK);
      end
      check("pwm_left_highs", 32'(cl), 9);
      check("pwm_right_highs", 32'(cr), 30);
      check("pwm_ticks", 32'(ct), 3);
      check("pwm_tick_phase", 32'(period_tick), 1);
      fork
        begin : count_side
          int c0, c1;
          c0 = 0; c1 = 0;
          for (int i = 0; i < 10; i++) begin c0 += int'(pwm_left); @(negedge ACLK); end
          check("pwm_tick_next", 32'(period_tick), 1);
          for (int i = 0; i < 10; i++) begin c1 += int'(pwm_left); @(negedge ACLK); end
          check("pwm_cur_period", 32'(c0), 3);
          check("pwm_next_period", 32'(c1), 5);
        end
        begin : write_side
          @(posedge ACLK); #1;
          cycles(3);
          axi_write(5'h04, 32'd5, 4'hF, 0, 0);
        end
      join
      @(posedge ACLK); #1;
    end

    // Reset with a write response pending and the PWM running
    axi_write(5'h00, 32'h7, 4'hF, 0, -1);
    cycles(1);
    @(negedge ACLK);
    check("t6_bvalid_pending", 32'(S_AXI_BVALID), 1);
    check("t6_pwm_right_run", 32'(pwm_right), 1);
    #2 ARESET = 1'b1;
    #1;
    check("t6_bvalid_rst", 32'(S_AXI_BVALID), 0);
    check("t6_outs_rst", {27'b0, pwm_left, pwm_right, dir_left, dir_right, period_tick}, 0);
    model_reset();
    @(posedge ACLK); #1 ARESET = 1'b0;
    for (int i = 0; i < 4; i++) axi_read(5'(i * 4), 0);
    axi_write(5'h00, 32'h6, 4'hF, 0, 0);
    axi_read(5'h00, 0);
    @(negedge ACLK);
    check("t6_dirs", {30'b0, dir_left, dir_right}, 32'h3);

    cycles(4);
    check("exp_b_drained", exp_b.size(), 0);
    check("exp_r_drained", exp_r.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
